serial_frame_shifter: RTL and testbench
=======================================

# serial_frame_shifter

Parametrised full-duplex shift engine for Hamming codeword transport. It accepts a parallel word through a valid/ready handshake and shifts it out serially, LSB- or MSB-first. At the same time it captures WIDTH incoming serial bits and presents the received word through a second valid/ready handshake. It sits between the encoder/decoder datapath and the serial line. A bit-enable input paces the line rate.

## Interface
- WIDTH, 7, word length in bits; must be ≥ 2.
- LSB_FIRST, 1, 1: shift right (bit 0 on the line first); 0: shift left (bit WIDTH-1 first).
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- bit_en  in  1  line-rate tick; one shift per cycle in which it is high during SHIFT
- abort  in  1  synchronous abort of the current frame
- load_valid  in  1  parallel word offered
- load_ready  out  1  engine can accept a word (high only in IDLE)
- load_data  in  WIDTH  word to transmit
- serial_in  in  1  received line bit, sampled on bit_en edges
- serial_out  out  1  transmitted line bit (registered data bit)
- out_valid  out  1  received word available (high only in DONE)
- out_ready  in  1  consumer takes received word
- out_data  out  WIDTH  shift register contents
- busy  out  1  high in SHIFT or DONE

## Operation
- Internal state:
  - data register, WIDTH bits.
  - bit counter, $clog2(WIDTH) bits.
  - FSM with states IDLE, SHIFT, DONE.
- Reset:
  - state=IDLE, data=0, count=0.
  - After the reset edge: load_ready=1, out_valid=0, busy=0, serial_out=0, out_data=0.
- Priority each edge: reset > abort > normal FSM.
- IDLE:
  - If load_valid && load_ready: data<=load_data, count<=0, go to SHIFT.
  - bit_en is ignored.
- SHIFT, on a cycle with bit_en=1:
  - LSB_FIRST=1: data<={serial_in, data[WIDTH-1:1]}.
  - LSB_FIRST=0: data<={data[WIDTH-2:0], serial_in}.
  - count<=count+1.
  - If count==WIDTH-1: go to DONE with count<=0.
- SHIFT, on a cycle with bit_en=0: hold all state.
- DONE:
  - out_valid=1, out_data=data, which now holds the received word.
  - out_valid && out_ready: go to IDLE; data is kept.
  - bit_en is ignored.
- serial_out:
  - LSB_FIRST=1: data[0].
  - LSB_FIRST=0: data[WIDTH-1].
  - Valid in every state.
- abort in SHIFT or DONE: next state IDLE, count<=0, data unchanged, out_valid drops. abort in IDLE has no effect.
- A load and a drain never coincide: load_ready is 0 in DONE.
- Loopback (serial_in=serial_out) rotates the word a full turn, so out_data==original load_data.

## Timing
- load_ready, out_valid and busy decode combinationally from the registered state. No combinational path from any input to any output.
- Acceptance edge E0: the first line bit appears on serial_out in the cycle after E0.
- bit_en during the acceptance cycle is not counted.
- With bit_en tied high: WIDTH shift edges E1..EWIDTH; out_valid is high in the cycle after EWIDTH.
  - load→out_valid latency = WIDTH cycles after the acceptance edge.
  - Back-to-back frame period = WIDTH+2 cycles with out_ready=1 and load_valid=1.
- With bit_en pulsed every k cycles: latency ≤ WIDTH·k cycles after acceptance.
- Each line bit is held on serial_out until the bit_en edge that captures serial_in.
- out_data is stable for the whole time out_valid is high, however long out_ready stays low.
- Reset mid-frame takes effect at the next edge; no partial word is ever flagged valid.

## Test plan
- WIDTH=7, LSB_FIRST=1, bit_en=1: load 7'h59, drive serial_in 0,1,0,1,0,1,0 (7'h2A LSB-first) -> serial_out 1,0,0,1,1,0,1; out_valid exactly 7 cycles after acceptance; out_data=7'h2A; load_ready=1 one cycle after out_ready.
- Loopback serial_in=serial_out, LSB_FIRST=0, load 7'h4B -> out_data=7'h4B. Repeat with LSB_FIRST=1 -> out_data=7'h4B.
- bit_en pulsed every 3rd cycle, load 7'h7F -> exactly 7 shifts; out_valid ≤ 21 cycles after acceptance; serial_out changes only after bit_en edges.
- Back-pressure: out_ready low 5 cycles in DONE, with bit_en and load_valid toggling -> out_valid held, out_data stable, load_ready=0, no shift.
- abort after 3 bits -> IDLE next cycle, busy=0, load_ready=1, out_valid never asserts. A subsequent load completes normally.
- reset asserted mid-SHIFT and during DONE -> after the edge: out_valid=0, serial_out=0, out_data=0, load_ready=1. The next frame has correct latency.

Source files
------------

// File: rtl/serial_frame_shifter.sv
// Full-duplex serial shift engine: a parallel word goes out on the line while a WIDTH-bit
// word is captured from the line, with valid/ready handshakes on both parallel sides.
module serial_frame_shifter #(
    parameter int unsigned WIDTH     = 7,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            data  <= '0;
            count <= '0;
        end else if (abort && state != StIdle) begin
            // Abandon the frame but keep the partial word for inspection.
            state <= StIdle;
            count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (load_valid) begin
                        data  <= load_data;
                        count <= '0;
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (bit_en) begin
                        if (LSB_FIRST) begin
                            data <= {serial_in, data[WIDTH-1:1]};
                        end else begin
                            data <= {data[WIDTH-2:0], serial_in};
                        end
                        if (count == LAST) begin
                            count <= '0;
                            state <= StDone;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign load_ready = (state == StIdle);
    assign out_valid  = (state == StDone);
    assign busy       = (state == StShift) || (state == StDone);
    assign out_data   = data;
    assign serial_out = LSB_FIRST ? data[0] : data[WIDTH-1];

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Directed bench for serial_frame_shifter: one LSB-first instance (driven or looped back)
// and one MSB-first instance in permanent loopback.
module tb_serial_frame_shifter;

    logic       clk = 1'b0;
    logic       reset;

    logic       l_bit_en, l_abort, l_load_valid, l_load_ready, l_serial_in, l_serial_out;
    logic       l_out_valid, l_out_ready, l_busy, l_loop, l_drive_in;
    logic [6:0] l_load_data, l_out_data;

    logic       m_bit_en, m_abort, m_load_valid, m_load_ready, m_serial_in, m_serial_out;
    logic       m_out_valid, m_out_ready, m_busy;
    logic [6:0] m_load_data, m_out_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign l_serial_in = l_loop ? l_serial_out : l_drive_in;
    assign m_serial_in = m_serial_out;
    assign m_abort     = 1'b0;

    serial_frame_shifter #(.WIDTH(7), .LSB_FIRST(1'b1)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (l_bit_en),
        .abort      (l_abort),
        .load_valid (l_load_valid),
        .load_ready (l_load_ready),
        .load_data  (l_load_data),
        .serial_in  (l_serial_in),
        .serial_out (l_serial_out),
        .out_valid  (l_out_valid),
        .out_ready  (l_out_ready),
        .out_data   (l_out_data),
        .busy       (l_busy)
    );

    serial_frame_shifter #(.WIDTH(7), .LSB_FIRST(1'b0)) dut_msb (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (m_bit_en),
        .abort      (m_abort),
        .load_valid (m_load_valid),
        .load_ready (m_load_ready),
        .load_data  (m_load_data),
        .serial_in  (m_serial_in),
        .serial_out (m_serial_out),
        .out_valid  (m_out_valid),
        .out_ready  (m_out_ready),
        .out_data   (m_out_data),
        .busy       (m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Loopback frame on the selected instance with bit_en tied high; reports latency and word.
    task automatic run_loop(input bit sel_msb, input logic [6:0] d,
                            output int lat, output logic [6:0] word);
        @(negedge clk);
        if (sel_msb) begin
            m_load_valid = 1'b1; m_load_data = d; m_bit_en = 1'b1;
        end else begin
            l_loop = 1'b1; l_load_valid = 1'b1; l_load_data = d; l_bit_en = 1'b1;
        end
        @(negedge clk);
        m_load_valid = 1'b0;
        l_load_valid = 1'b0;
        lat = 0;
        while (!(sel_msb ? m_out_valid : l_out_valid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        word = sel_msb ? m_out_data : l_out_data;
        if (sel_msb) m_out_ready = 1'b1; else l_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0; m_bit_en = 1'b0;
        l_out_ready = 1'b0; l_bit_en = 1'b0; l_loop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, l_load_ready, 1);
        check({tag, "_out_valid"}, l_out_valid, 0);
        check({tag, "_serial_out"}, l_serial_out, 0);
        check({tag, "_out_data"}, l_out_data, 0);
    endtask

    initial begin
        int          lat;
        int          pulses;
        bit          prev_en;
        logic        prev_so;
        logic [6:0]  word;
        logic [6:0]  tx, rx;
        bit          saw_valid;

        reset = 1'b1;
        l_bit_en = 0; l_abort = 0; l_load_valid = 0; l_load_data = '0; l_out_ready = 0;
        l_loop = 0; l_drive_in = 0;
        m_bit_en = 0; m_load_valid = 0; m_load_data = '0; m_out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_busy", l_busy, 0);
        reset = 1'b0;

        // Driven frame: transmit 0x59, receive 0x2A LSB-first.
        tx = 7'h59;
        rx = 7'h2A;
        l_load_valid = 1'b1; l_load_data = tx; l_bit_en = 1'b1;
        @(negedge clk);
        l_load_valid = 1'b0;
        check("t1_busy", l_busy, 1);
        check("t1_load_ready", l_load_ready, 0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1_so%0d", i), l_serial_out, tx[i]);
            check($sformatf("t1_ov%0d", i), l_out_valid, 0);
            l_drive_in = rx[i];
            @(negedge clk);
        end
        check("t1_ov_at7", l_out_valid, 1);
        check("t1_out_data", l_out_data, 7'h2A);
        l_out_ready = 1'b1;
        @(negedge clk);
        l_out_ready = 1'b0;
        check("t1_load_ready_after", l_load_ready, 1);
        check("t1_ov_after", l_out_valid, 0);
        check("t1_data_kept", l_out_data, 7'h2A);

        // Loopback in both bit orders.
        run_loop(1'b1, 7'h4B, lat, word);
        check("t2_msb_word", word, 7'h4B);
        check("t2_msb_lat", lat, 7);
        run_loop(1'b0, 7'h4B, lat, word);
        check("t2_lsb_word", word, 7'h4B);
        check("t2_lsb_lat", lat, 7);

        // bit_en every third cycle; bit_en high in the acceptance cycle must not count.
        rx = 7'h15;
        l_load_valid = 1'b1; l_load_data = 7'h7F; l_bit_en = 1'b1;
        @(negedge clk);
        l_load_valid = 1'b0;
        lat = 0;
        pulses = 0;
        prev_so = l_serial_out;
        prev_en = 1'b0;
        l_bit_en = 1'b0;
        while (!l_out_valid && lat < 60) begin
            prev_en = l_bit_en;
            l_bit_en = (lat % 3 == 2);
            if (l_bit_en) begin
                l_drive_in = rx[pulses];
                pulses++;
            end
            @(negedge clk);
            lat++;
            if (l_serial_out !== prev_so) check("t3_so_on_bit_en", l_bit_en, 1);
            prev_so = l_serial_out;
        end
        check("t3_lat", lat, 21);
        check("t3_word", l_out_data, 7'h15);

        // Back-pressure in DONE with bit_en and load_valid toggling.
        l_load_data = 7'h00;
        l_drive_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            l_bit_en = i[0];
            l_load_valid = ~i[0];
            @(negedge clk);
            check($sformatf("t4_ov%0d", i), l_out_valid, 1);
            check($sformatf("t4_data%0d", i), l_out_data, 7'h15);
            check($sformatf("t4_lr%0d", i), l_load_ready, 0);
        end
        l_bit_en = 1'b0; l_load_valid = 1'b0; l_out_ready = 1'b1;
        @(negedge clk);
        l_out_ready = 1'b0;
        check("t4_drained", l_load_ready, 1);

        // Abort after three bits with serial_in low: 0x59 >> 3 = 0x0B remains.
        l_drive_in = 1'b0;
        l_load_valid = 1'b1; l_load_data = 7'h59; l_bit_en = 1'b1;
        @(negedge clk);
        l_load_valid = 1'b0;
        repeat (3) @(negedge clk);
        l_abort = 1'b1;
        @(negedge clk);
        l_abort = 1'b0; l_bit_en = 1'b0;
        check("t5_busy", l_busy, 0);
        check("t5_load_ready", l_load_ready, 1);
        check("t5_partial", l_out_data, 7'h0B);
        saw_valid = 1'b0;
        l_bit_en = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (l_out_valid) saw_valid = 1'b1;
        end
        l_bit_en = 1'b0;
        check("t5_no_valid", saw_valid, 0);
        run_loop(1'b0, 7'h2A, lat, word);
        check("t5_next_word", word, 7'h2A);
        check("t5_next_lat", lat, 7);

        // Reset mid-SHIFT.
        l_load_valid = 1'b1; l_load_data = 7'h59; l_bit_en = 1'b1;
        @(negedge clk);
        l_load_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; l_bit_en = 1'b0;
        check_reset_outputs("t6_shift");

        // Reset while in DONE.
        l_loop = 1'b1; l_load_valid = 1'b1; l_load_data = 7'h33; l_bit_en = 1'b1;
        @(negedge clk);
        l_load_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("t6_in_done", l_out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; l_bit_en = 1'b0; l_loop = 1'b0;
        check_reset_outputs("t6_done");
        run_loop(1'b0, 7'h66, lat, word);
        check("t6_next_word", word, 7'h66);
        check("t6_next_lat", lat, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
